fetch_stage_buf: RTL and testbench
==================================

# fetch_stage_buf

Parametrised fetch stage for the PE array. It captures one operand beat per row (input, weight, partial sum) plus a control sideband from the upstream MAIN rdy/ack channel, and unpacks packed partial sums into N-way lanes. It masks disabled rows and presents the beat downstream on the FS rdy/ack channel. A 2-entry skid buffer sustains one beat per cycle under backpressure, with flush and transfer counting. It sits between the input/weight/psum pads and the multiply stage.

## Interface
Parameters:
- NROW, 4, number of PE rows
- DWD, 16, input/weight width per row
- PSUMDWD, 64, packed psum width per row
- NLANE, 4, psum lanes when split; PSUMDWD % NLANE == 0; lane width LW = PSUMDWD/NLANE
- SIDEW, 32, sideband (control) width carried with each beat
- CNTW, 16, transfer counter width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; **synchronous, active-high**
- i_main_rdy  in  1  upstream beat valid
- o_main_ack  out  1  upstream beat accepted when i_main_rdy && o_main_ack
- o_fs_rdy  out  1  downstream beat valid
- i_fs_ack  in  1  downstream accepts when o_fs_rdy && i_fs_ack
- i_flush  in  1  discard all buffered beats
- i_psum_split  in  1  0 = full psum; 1 = lane select
- i_psum_sel  in  $clog2(NLANE)  lane index when split
- i_row_en  in  NROW  per-row enable
- i_side  in  SIDEW  sideband
- i_input, i_weight  in  NROW*DWD  row-packed operands, row r at [r*DWD +: DWD]
- i_psum  in  NROW*PSUMDWD  row-packed psums
- o_input, o_weight  out  NROW*DWD  head-beat operands
- o_psum  out  NROW*PSUMDWD  head-beat psums, after unpacking
- o_side  out  SIDEW  head-beat sideband
- o_row_en  out  NROW  head-beat row enables
- o_occ  out  2  buffer occupancy, 0..2
- o_xfer_cnt  out  CNTW  completed downstream transfers

## Operation
- Accept (acc) = i_main_rdy && o_main_ack. Pop = o_fs_rdy && i_fs_ack.
- Psum unpack is applied per row at accept time, and the stored value is registered:
  - split=0: psum passes unchanged.
  - split=1: psum = zero-extended (psum >> (sel*LW)) & {LW{1'b1}}.
- Row masking: a row with i_row_en[r]=0 stores zero input, weight and psum. Its enable bit is stored as 0.
- Buffer is a 2-entry FIFO holding {side, row_en, input, weight, psum}. The head entry drives all o_* data outputs.
- o_main_ack = !i_rst && (occ < 2). o_fs_rdy = (occ != 0).
- Occupancy update:
  - acc && !pop: +1
  - pop && !acc: -1
  - both: unchanged; head advances and the new beat is written to the tail
- Flush: the next cycle has occ=0. An accept in the flush cycle is discarded, and a pop in that cycle still counts. o_xfer_cnt is not cleared.
- o_xfer_cnt increments on every pop and wraps from 2^CNTW-1 to 0.
- Data outputs with occ=0 hold their last value. Downstream must ignore them while o_fs_rdy=0.

## Timing
- Reset (i_rst high at a clock edge):
  - occ=0, o_fs_rdy=0, o_xfer_cnt=0.
  - All data outputs, o_side and o_row_en are 0.
  - o_main_ack=0 while i_rst is high.
- Reset asserted mid-transfer discards buffered beats. No pop is counted for that cycle.
- Latency: a beat accepted at edge N has o_fs_rdy=1 after edge N, i.e. it is visible in cycle N+1.
- Throughput is 1 beat/cycle when i_fs_ack is held high.
- Full (occ=2): o_main_ack=0. A pop that cycle makes o_main_ack=1 from the next cycle.
- Empty (occ=0): no pop is possible. An accept and flush in the same cycle leave occ=0.
- Downstream must keep i_fs_ack meaningful only with o_fs_rdy. Upstream must hold i_main_rdy and its data until acked.

## Configuration
- FETCH_SKID_EN defined: 2-entry skid FIFO as above, full throughput.
- FETCH_SKID_EN undefined: single register entry.
  - o_main_ack = !i_rst && (occ==0), so accept and pop in the same cycle are impossible.
  - Maximum throughput is 1 beat per 2 cycles.
  - o_occ ranges over 0..1. All other behaviour is identical.

## Test plan
- Reset then idle:
  - o_fs_rdy=0, o_occ=0, o_xfer_cnt=0, all data outputs 0, o_main_ack=0 during reset.
  - o_main_ack=1 after reset is released.
- Streaming, i_fs_ack=1, 8 beats with i_input row0=beat index:
  - Each beat appears one cycle after accept, in order.
  - With skid, 8 beats complete in 9 cycles and o_xfer_cnt=8.
  - Without skid, they complete in 16 cycles.
- Backpressure, i_fs_ack=0 for 5 cycles while upstream offers 3 beats:
  - The first two are accepted, o_occ=2, o_main_ack=0.
  - On release, beats emerge in order with no loss.
- Psum unpack, PSUMDWD=64, NLANE=4, psum=64'h4444_3333_2222_1111:
  - sel=2 gives o_psum=64'h3333.
  - split=0 gives the full value.
  - i_row_en[1]=0 gives zeros on row 1 and o_row_en[1]=0.
- Flush at occ=2 with a simultaneous accept and pop:
  - Next cycle occ=0 and o_fs_rdy=0.
  - o_xfer_cnt increments by 1.
- Counter wrap, CNTW=4, 17 pops: o_xfer_cnt=1.

Source files
------------

// File: rtl/fetch_stage_buf.sv
// Fetch stage: captures masked, psum-unpacked operand beats from MAIN and replays them on FS.
// FETCH_SKID_EN selects a 2-entry skid FIFO; otherwise a single register entry is used.
module fetch_stage_buf #(
  parameter int NROW    = 4,
  parameter int DWD     = 16,
  parameter int PSUMDWD = 64,
  parameter int NLANE   = 4,
  parameter int SIDEW   = 32,
  parameter int CNTW    = 16,
  localparam int SELW   = (NLANE > 1) ? $clog2(NLANE) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_main_rdy,
  output logic                    o_main_ack,
  output logic                    o_fs_rdy,
  input  logic                    i_fs_ack,
  input  logic                    i_flush,
  input  logic                    i_psum_split,
  input  logic [SELW-1:0]         i_psum_sel,
  input  logic [NROW-1:0]         i_row_en,
  input  logic [SIDEW-1:0]        i_side,
  input  logic [NROW*DWD-1:0]     i_input,
  input  logic [NROW*DWD-1:0]     i_weight,
  input  logic [NROW*PSUMDWD-1:0] i_psum,
  output logic [NROW*DWD-1:0]     o_input,
  output logic [NROW*DWD-1:0]     o_weight,
  output logic [NROW*PSUMDWD-1:0] o_psum,
  output logic [SIDEW-1:0]        o_side,
  output logic [NROW-1:0]         o_row_en,
  output logic [1:0]              o_occ,
  output logic [CNTW-1:0]         o_xfer_cnt
);

  localparam int LW = PSUMDWD / NLANE;
`ifdef FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [SIDEW-1:0]        side;
    logic [NROW-1:0]         row_en;
    logic [NROW*DWD-1:0]     inp;
    logic [NROW*DWD-1:0]     wgt;
    logic [NROW*PSUMDWD-1:0] psum;
  } entry_t;

  entry_t             mem [0:1];
  entry_t             new_entry;
  entry_t             head;
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         occ;
  logic [CNTW-1:0]    xfer_cnt;
  logic [PSUMDWD-1:0] psum_row;
  logic [PSUMDWD-1:0] lane_mask;
  logic               acc;
  logic               pop;

  function automatic logic adv(input logic p);
    return (DEPTH == 2) ? ~p : 1'b0;
  endfunction

  assign o_main_ack = !i_rst && (occ < 2'(DEPTH));
  assign o_fs_rdy   = (occ != 2'd0);
  assign acc        = i_main_rdy && o_main_ack;
  assign pop        = o_fs_rdy && i_fs_ack;

  // Row masking and lane extraction happen before storage so the head is already final.
  always_comb begin
    lane_mask         = '0;
    lane_mask[LW-1:0] = '1;
    psum_row          = '0;
    new_entry         = '0;
    new_entry.side    = i_side;
    new_entry.row_en  = i_row_en;
    for (int r = 0; r < NROW; r++) begin
      if (i_row_en[r]) begin
        new_entry.inp[r*DWD +: DWD] = i_input[r*DWD +: DWD];
        new_entry.wgt[r*DWD +: DWD] = i_weight[r*DWD +: DWD];
        psum_row = i_psum[r*PSUMDWD +: PSUMDWD];
        if (i_psum_split) begin
          psum_row = (psum_row >> (int'(i_psum_sel) * LW)) & lane_mask;
        end
        new_entry.psum[r*PSUMDWD +: PSUMDWD] = psum_row;
      end
    end
  end

  // When the buffer drains, the read pointer stays put so the outputs hold the last head.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      occ      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      xfer_cnt <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      if (pop) begin
        xfer_cnt <= xfer_cnt + CNTW'(1);
      end
      if (i_flush) begin
        occ    <= 2'd0;
        wr_ptr <= rd_ptr;
      end else begin
        case ({acc, pop})
          2'b10: begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= adv(wr_ptr);
            occ         <= occ + 2'd1;
          end
          2'b01: begin
            occ <= occ - 2'd1;
            if (occ == 2'd1) begin
              wr_ptr <= rd_ptr;
            end else begin
              rd_ptr <= adv(rd_ptr);
            end
          end
          2'b11: begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= adv(wr_ptr);
            rd_ptr      <= adv(rd_ptr);
          end
          default: ;
        endcase
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign o_side     = head.side;
  assign o_row_en   = head.row_en;
  assign o_input    = head.inp;
  assign o_weight   = head.wgt;
  assign o_psum     = head.psum;
  assign o_occ      = occ;
  assign o_xfer_cnt = xfer_cnt;

endmodule

// File: tb/tb_fetch_stage_buf.sv
// Directed plus randomized bench for fetch_stage_buf against a queue-based beat model.
// Honours FETCH_SKID_EN to pick the expected buffer depth.
module tb_fetch_stage_buf;

  localparam int NROW    = 4;
  localparam int DWD     = 16;
  localparam int PSUMDWD = 64;
  localparam int NLANE   = 4;
  localparam int SIDEW   = 32;
  localparam int CNTW    = 4;
  localparam int LW      = PSUMDWD / NLANE;
`ifdef FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic                    i_clk;
  logic                    i_rst;
  logic                    i_main_rdy;
  logic                    o_main_ack;
  logic                    o_fs_rdy;
  logic                    i_fs_ack;
  logic                    i_flush;
  logic                    i_psum_split;
  logic [1:0]              i_psum_sel;
  logic [NROW-1:0]         i_row_en;
  logic [SIDEW-1:0]        i_side;
  logic [NROW*DWD-1:0]     i_input;
  logic [NROW*DWD-1:0]     i_weight;
  logic [NROW*PSUMDWD-1:0] i_psum;
  logic [NROW*DWD-1:0]     o_input;
  logic [NROW*DWD-1:0]     o_weight;
  logic [NROW*PSUMDWD-1:0] o_psum;
  logic [SIDEW-1:0]        o_side;
  logic [NROW-1:0]         o_row_en;
  logic [1:0]              o_occ;
  logic [CNTW-1:0]         o_xfer_cnt;

  fetch_stage_buf #(
    .NROW(NROW), .DWD(DWD), .PSUMDWD(PSUMDWD), .NLANE(NLANE), .SIDEW(SIDEW), .CNTW(CNTW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_main_rdy(i_main_rdy), .o_main_ack(o_main_ack),
    .o_fs_rdy(o_fs_rdy), .i_fs_ack(i_fs_ack), .i_flush(i_flush),
    .i_psum_split(i_psum_split), .i_psum_sel(i_psum_sel), .i_row_en(i_row_en),
    .i_side(i_side), .i_input(i_input), .i_weight(i_weight), .i_psum(i_psum),
    .o_input(o_input), .o_weight(o_weight), .o_psum(o_psum), .o_side(o_side),
    .o_row_en(o_row_en), .o_occ(o_occ), .o_xfer_cnt(o_xfer_cnt)
  );

  typedef struct packed {
    logic [SIDEW-1:0]        side;
    logic [NROW-1:0]         ren;
    logic [NROW*DWD-1:0]     inp;
    logic [NROW*DWD-1:0]     wgt;
    logic [NROW*PSUMDWD-1:0] ps;
  } beat_t;

  beat_t q[$];
  beat_t last;
  int    total = 0;
  int    bad = 0;
  int    m_cnt = 0;
  int    npop = 0;
  bit    m_acc;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected stored beat, computed from the input rules by lane slicing.
  function automatic beat_t build();
    beat_t b;
    logic [PSUMDWD-1:0] p;
    b = '0;
    b.side = i_side;
    b.ren  = i_row_en;
    for (int r = 0; r < NROW; r++) begin
      if (i_row_en[r]) begin
        b.inp[r*DWD +: DWD] = i_input[r*DWD +: DWD];
        b.wgt[r*DWD +: DWD] = i_weight[r*DWD +: DWD];
        p = i_psum[r*PSUMDWD +: PSUMDWD];
        if (i_psum_split) p = {{(PSUMDWD-LW){1'b0}}, p[int'(i_psum_sel)*LW +: LW]};
        b.ps[r*PSUMDWD +: PSUMDWD] = p;
      end
    end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    if (q.size() != 0) last = q[0];
    checkOutput("occ", o_occ, q.size());
    checkOutput("fs_rdy", o_fs_rdy, q.size() != 0);
    checkOutput("xfer_cnt", o_xfer_cnt, m_cnt);
    checkOutput("side", o_side, last.side);
    checkOutput("row_en", o_row_en, last.ren);
    checkOutput("input", o_input, last.inp);
    checkOutput("weight", o_weight, last.wgt);
    checkOutput("psum", o_psum, last.ps);
  endtask

  // Called at a negedge with inputs already driven; advances one clock and checks.
  task automatic applyStimulus();
    bit    exp_ack;
    bit    m_pop;
    beat_t nb;
    #1;
    exp_ack = !i_rst && (q.size() < DEPTH);
    checkOutput("main_ack", o_main_ack, exp_ack);
    m_acc = i_main_rdy && exp_ack;
    m_pop = (q.size() != 0) && i_fs_ack && !i_rst;
    nb = build();
    @(posedge i_clk);
    if (i_rst) begin
      q.delete();
      m_cnt = 0;
      last = '0;
    end else begin
      if (m_pop) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNTW);
        npop++;
      end
      if (i_flush) q.delete();
      else if (m_acc) q.push_back(nb);
    end
    @(negedge i_clk);
    checkAll();
  endtask

  task automatic randData();
    i_side   = $urandom;
    i_input  = {$urandom, $urandom};
    i_weight = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) i_psum[i*32 +: 32] = $urandom;
  endtask

  initial begin
    int k;
    int cycles;
    int start;
    int pre;
    i_rst = 1'b1; i_main_rdy = 1'b1; i_fs_ack = 1'b0; i_flush = 1'b0;
    i_psum_split = 1'b0; i_psum_sel = 2'd0; i_row_en = '1;
    randData();
    @(negedge i_clk);

    // Reset then idle
    repeat (2) applyStimulus();
    checkOutput("rst_psum", o_psum, 0);
    checkOutput("rst_occ", o_occ, 0);
    i_rst = 1'b0; i_main_rdy = 1'b0;
    applyStimulus();
    checkOutput("ack_after_rst", o_main_ack, 1);

    // Streaming 8 beats with ack held high
    i_fs_ack = 1'b1; k = 0; cycles = 0; start = npop;
    while (npop - start < 8 && cycles < 40) begin
      i_main_rdy = (k < 8);
      i_input = {48'h0, 16'(k)};
      applyStimulus();
      cycles++;
      if (m_acc) k++;
    end
    checkOutput("stream_cycles", cycles, (DEPTH == 2) ? 9 : 16);
    checkOutput("stream_cnt", o_xfer_cnt, 8);

    // Backpressure: 3 beats offered while downstream stalls for 5 cycles
    i_fs_ack = 1'b0; k = 0;
    repeat (5) begin
      i_main_rdy = (k < 3);
      i_input = {48'h0, 16'(100 + k)};
      applyStimulus();
      if (m_acc) k++;
    end
    checkOutput("bp_occ", o_occ, DEPTH);
    checkOutput("bp_ack", o_main_ack, 0);
    i_fs_ack = 1'b1; cycles = 0;
    while ((k < 3 || q.size() != 0) && cycles < 20) begin
      i_main_rdy = (k < 3);
      i_input = {48'h0, 16'(100 + k)};
      applyStimulus();
      cycles++;
      if (m_acc) k++;
    end
    checkOutput("bp_drained", o_occ, 0);

    // Psum unpack and row masking
    randData();
    i_psum = {4{64'h4444_3333_2222_1111}};
    i_psum_split = 1'b1; i_psum_sel = 2'd2; i_fs_ack = 1'b0; i_main_rdy = 1'b1;
    applyStimulus();
    i_main_rdy = 1'b0;
    checkOutput("psum_lane2", o_psum[63:0], 64'h3333);
    i_fs_ack = 1'b1; applyStimulus(); i_fs_ack = 1'b0;
    i_psum_split = 1'b0; i_main_rdy = 1'b1;
    applyStimulus();
    i_main_rdy = 1'b0;
    checkOutput("psum_full", o_psum[63:0], 64'h4444_3333_2222_1111);
    i_fs_ack = 1'b1; applyStimulus(); i_fs_ack = 1'b0;
    i_row_en = 4'b1101; i_main_rdy = 1'b1;
    applyStimulus();
    i_main_rdy = 1'b0;
    checkOutput("row1_psum", o_psum[127:64], 0);
    checkOutput("row1_en", o_row_en[1], 0);
    checkOutput("row0_psum", o_psum[63:0], 64'h4444_3333_2222_1111);
    i_fs_ack = 1'b1; applyStimulus(); i_fs_ack = 1'b0;
    i_row_en = '1;

    // Flush with buffer full, simultaneous accept attempt and pop
    i_main_rdy = 1'b1;
    repeat (DEPTH) begin randData(); applyStimulus(); end
    pre = m_cnt;
    i_fs_ack = 1'b1; i_flush = 1'b1; randData();
    applyStimulus();
    i_flush = 1'b0; i_main_rdy = 1'b0; i_fs_ack = 1'b0;
    checkOutput("flush_occ", o_occ, 0);
    checkOutput("flush_rdy", o_fs_rdy, 0);
    checkOutput("flush_cnt", o_xfer_cnt, (pre + 1) % 16);

    // Reset in the middle of a transfer
    i_main_rdy = 1'b1; randData(); applyStimulus();
    i_rst = 1'b1; i_fs_ack = 1'b1; applyStimulus();
    i_rst = 1'b0;
    checkOutput("midrst_cnt", o_xfer_cnt, 0);

    // Counter wrap after 17 pops
    start = npop; cycles = 0;
    while (npop - start < 17 && cycles < 80) begin
      randData();
      i_main_rdy = 1'b1;
      applyStimulus();
      cycles++;
    end
    checkOutput("wrap_cnt", o_xfer_cnt, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      randData();
      i_main_rdy   = ($urandom_range(3) != 0);
      i_fs_ack     = ($urandom_range(2) != 0);
      i_flush      = ($urandom_range(19) == 0);
      i_rst        = ($urandom_range(59) == 0);
      i_psum_split = $urandom_range(1);
      i_psum_sel   = 2'($urandom_range(3));
      i_row_en     = 4'($urandom_range(15));
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
